// File: rtl/iob_gpio_irq.sv
// rtl/iob_gpio_irq.sv - GPIO peripheral on the IOb native bus with debounced inputs and edge interrupts
module iob_gpio_irq #(
  parameter int GPIO_W      = 32,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  output logic [DATA_W-1:0]     rdata,
  output logic                  ready,
  input  logic [GPIO_W-1:0]     gpio_input,
  output logic [GPIO_W-1:0]     gpio_output,
  output logic [GPIO_W-1:0]     gpio_output_enable,
  output logic                  irq
);

  localparam logic [ADDR_W-1:0] A_INPUT  = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_OUT    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_OE     = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_IEN    = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_IRISE  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_IFALL  = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(6);
  localparam logic [ADDR_W-1:0] A_DEB    = ADDR_W'(7);
  localparam logic [ADDR_W-1:0] A_SET    = ADDR_W'(8);
  localparam logic [ADDR_W-1:0] A_CLR    = ADDR_W'(9);

  logic [GPIO_W-1:0] out_q, out_d, oe_q, oe_d, ien_q, ien_d;
  logic [GPIO_W-1:0] irise_q, irise_d, ifall_q, ifall_d, status_q, status_d;
  logic [GPIO_W-1:0] samp_q, samp_d, deb_q, deb_d, prev_q, prev_d;
  logic [SYNC_STAGES-1:0][GPIO_W-1:0] sync_q, sync_d;
  logic [DEBOUNCE_W-1:0] period_q, period_d, cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ready_q, ready_d;

  logic [DATA_W-1:0] bmask;
  logic [GPIO_W-1:0] wsel, gmask, w1c, set, stable, sync_last;
  logic              we, re, cnt_clr;

  function automatic logic [DATA_W-1:0] zx_g(input logic [GPIO_W-1:0] v);
    zx_g = '0;
    zx_g[GPIO_W-1:0] = v;
  endfunction

  function automatic logic [DATA_W-1:0] zx_d(input logic [DEBOUNCE_W-1:0] v);
    zx_d = '0;
    zx_d[DEBOUNCE_W-1:0] = v;
  endfunction

  always_comb begin
    for (int b = 0; b < DATA_W/8; b++) bmask[8*b +: 8] = {8{wstrb[b]}};
    gmask     = bmask[GPIO_W-1:0];
    wsel      = wdata[GPIO_W-1:0] & gmask;
    we        = valid & (|wstrb);
    re        = valid & ~(|wstrb);
    out_d     = out_q;
    oe_d      = oe_q;
    ien_d     = ien_q;
    irise_d   = irise_q;
    ifall_d   = ifall_q;
    period_d  = period_q;
    w1c       = '0;
    cnt_clr   = 1'b0;
    if (we) begin
      case (address)
        A_OUT:    out_d   = (out_q & ~gmask) | wsel;
        A_OE:     oe_d    = (oe_q & ~gmask) | wsel;
        A_IEN:    ien_d   = (ien_q & ~gmask) | wsel;
        A_IRISE:  irise_d = (irise_q & ~gmask) | wsel;
        A_IFALL:  ifall_d = (ifall_q & ~gmask) | wsel;
        A_STATUS: w1c     = wsel;
        A_DEB: begin
          period_d = (period_q & ~bmask[DEBOUNCE_W-1:0]) |
                     (wdata[DEBOUNCE_W-1:0] & bmask[DEBOUNCE_W-1:0]);
          cnt_clr  = 1'b1;
        end
        A_SET:    out_d   = out_q | wsel;
        A_CLR:    out_d   = out_q & ~wsel;
        default:  ;
      endcase
    end

    sync_d    = {sync_q[SYNC_STAGES-2:0], gpio_input};
    sync_last = sync_q[SYNC_STAGES-1];

    // A pin only moves deb when it matched at two consecutive ticks.
    samp_d = samp_q;
    deb_d  = deb_q;
    stable = ~(sync_last ^ samp_q);
    cnt_d  = '0;
    if (period_q == '0) begin
      deb_d = sync_last;
    end else if (cnt_q == period_q) begin
      samp_d = sync_last;
      deb_d  = (deb_q & ~stable) | (sync_last & stable);
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    if (cnt_clr) cnt_d = '0;

    prev_d   = deb_q;
    set      = (deb_q & ~prev_q & irise_q) | (~deb_q & prev_q & ifall_q);
    status_d = (status_q & ~w1c) | set;

    rdata_d = '0;
    if (re) begin
      case (address)
        A_INPUT:  rdata_d = zx_g(deb_q);
        A_OUT:    rdata_d = zx_g(out_q);
        A_OE:     rdata_d = zx_g(oe_q);
        A_IEN:    rdata_d = zx_g(ien_q);
        A_IRISE:  rdata_d = zx_g(irise_q);
        A_IFALL:  rdata_d = zx_g(ifall_q);
        A_STATUS: rdata_d = zx_g(status_q);
        A_DEB:    rdata_d = zx_d(period_q);
        default:  rdata_d = '0;
      endcase
    end
    ready_d = valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q    <= '0;
      oe_q     <= '0;
      ien_q    <= '0;
      irise_q  <= '0;
      ifall_q  <= '0;
      status_q <= '0;
      samp_q   <= '0;
      deb_q    <= '0;
      prev_q   <= '0;
      sync_q   <= '0;
      period_q <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      out_q    <= out_d;
      oe_q     <= oe_d;
      ien_q    <= ien_d;
      irise_q  <= irise_d;
      ifall_q  <= ifall_d;
      status_q <= status_d;
      samp_q   <= samp_d;
      deb_q    <= deb_d;
      prev_q   <= prev_d;
      sync_q   <= sync_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      ready_q  <= ready_d;
    end
  end

  assign rdata              = rdata_q;
  assign ready              = ready_q;
  assign gpio_output        = out_q;
  assign gpio_output_enable = oe_q;
  assign irq                = |(status_q & ien_q);

endmodule

// File: tb/tb_iob_gpio_irq.sv
// tb/tb_iob_gpio_irq.sv - scoreboard bench for iob_gpio_irq (32-pin and 8-pin instances)
`timescale 1ns/1ps
module tb_iob_gpio_irq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        valid = 1'b0, valid8 = 1'b0;
  logic [3:0]  address = '0, address8 = '0;
  logic [31:0] wdata = '0, wdata8 = '0;
  logic [3:0]  wstrb = '0, wstrb8 = '0;
  logic [31:0] rdata, rdata8;
  logic        ready, ready8, irq, irq8;
  logic [31:0] gpio_input = '0, gpio_output, gpio_output_enable;
  logic [7:0]  gpio_input8 = '0, gpio_output8, gpio_output_enable8;

  iob_gpio_irq u_dut (
    .clk(clk), .rst(rst), .valid(valid), .address(address), .wdata(wdata),
    .wstrb(wstrb), .rdata(rdata), .ready(ready), .gpio_input(gpio_input),
    .gpio_output(gpio_output), .gpio_output_enable(gpio_output_enable), .irq(irq)
  );

  iob_gpio_irq #(.GPIO_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .valid(valid8), .address(address8), .wdata(wdata8),
    .wstrb(wstrb8), .rdata(rdata8), .ready(ready8), .gpio_input(gpio_input8),
    .gpio_output(gpio_output8), .gpio_output_enable(gpio_output_enable8), .irq(irq8)
  );

  typedef struct {
    logic [31:0] val;
    bit          chk;
    string       name;
  } exp_t;

  exp_t sbq[$];
  exp_t sbq8[$];
  int   n_vec = 0;
  int   n_bad = 0;
  logic v_s = 1'b0, v8_s = 1'b0;

  always @(posedge clk) begin
    v_s  <= valid;
    v8_s <= valid8;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bus(input bit d8, input logic [3:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic [31:0] e, input string name);
    exp_t x;
    x.val = e; x.chk = (s == 4'h0); x.name = name;
    @(posedge clk); #1;
    if (d8) begin
      valid8 = 1'b1; address8 = a; wdata8 = d; wstrb8 = s; sbq8.push_back(x);
    end else begin
      valid = 1'b1; address = a; wdata = d; wstrb = s; sbq.push_back(x);
    end
    @(posedge clk); #1;
    valid = 1'b0; valid8 = 1'b0; wstrb = '0; wstrb8 = '0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus(1'b0, a, d, 4'hF, 32'h0, "wr");
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] e, input string name);
    bus(1'b0, a, 32'h0, 4'h0, e, name);
  endtask

  // Monitor: ready must follow valid by exactly one cycle; each ack retires one entry.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ready || v_s) check("ready_timing", {31'b0, ready}, {31'b0, v_s});
        if (ready8 || v8_s) check("ready8_timing", {31'b0, ready8}, {31'b0, v8_s});
        if (ready) begin
          if (sbq.size() == 0) check("spurious_ready", 32'd1, 32'd0);
          else begin
            x = sbq.pop_front();
            if (x.chk) check(x.name, rdata, x.val);
          end
        end
        if (ready8) begin
          if (sbq8.size() == 0) check("spurious_ready8", 32'd1, 32'd0);
          else begin
            x = sbq8.pop_front();
            if (x.chk) check(x.name, rdata8, x.val);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_ready", {31'b0, ready}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_out", gpio_output, 32'h0);
    check("rst_oe", gpio_output_enable, 32'h0);

    for (int a = 0; a < 16; a++) rd(a[3:0], 32'h0, "t1_rd_reset");

    wr(4'd1, 32'hA5A5A5A5);
    wr(4'd8, 32'h0000000F);
    wr(4'd9, 32'h000000A0);
    bus(1'b0, 4'd1, 32'h0000FF00, 4'h2, 32'h0, "wr_strb");
    check("t2_gpio_out", gpio_output, 32'hA5A5FF0F);
    rd(4'd1, 32'hA5A5FF0F, "t2_rd_out");
    rd(4'd8, 32'h0, "t2_rd_set");
    rd(4'd9, 32'h0, "t2_rd_clr");
    wr(4'd2, 32'h12345678);
    check("t2_oe", gpio_output_enable, 32'h12345678);

    wr(4'd4, 32'h1);
    wr(4'd3, 32'h1);
    @(posedge clk); #1 gpio_input[0] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1 check("t3_irq_k2", {31'b0, irq}, 32'h0);
    @(posedge clk); #1 check("t3_irq_k3", {31'b0, irq}, 32'h1);
    rd(4'd0, 32'h1, "t3_input");
    rd(4'd6, 32'h1, "t3_status");
    wr(4'd6, 32'h1);
    check("t3_irq_w1c", {31'b0, irq}, 32'h0);
    gpio_input[0] = 1'b0;
    repeat (6) @(posedge clk);
    rd(4'd6, 32'h0, "t3_fall_ignored");
    @(posedge clk); #1 gpio_input[0] = 1'b1;
    repeat (2) @(posedge clk);
    wr(4'd6, 32'h1);
    check("t3_irq_set_wins", {31'b0, irq}, 32'h1);
    rd(4'd6, 32'h1, "t3_status_set_wins");
    wr(4'd6, 32'h1);
    check("t3_irq_clear2", {31'b0, irq}, 32'h0);

    gpio_input[1] = 1'b1;
    repeat (6) @(posedge clk);
    rd(4'd6, 32'h0, "t4_rise_not_enabled");
    wr(4'd5, 32'h2);
    wr(4'd3, 32'h0);
    gpio_input[1] = 1'b0;
    repeat (6) @(posedge clk);
    rd(4'd6, 32'h2, "t4_status_fall");
    check("t4_irq_masked", {31'b0, irq}, 32'h0);
    wr(4'd3, 32'h2);
    check("t4_irq_enabled", {31'b0, irq}, 32'h1);
    wr(4'd6, 32'h2);
    check("t4_irq_clear", {31'b0, irq}, 32'h0);

    wr(4'd4, 32'h4);
    wr(4'd5, 32'h4);
    wr(4'd7, 32'h3);
    rd(4'd7, 32'h3, "t5_debounce_reg");
    gpio_input[2] = 1'b1;
    repeat (2) @(posedge clk);
    #1 gpio_input[2] = 1'b0;
    repeat (12) @(posedge clk);
    rd(4'd0, 32'h1, "t5_glitch_input");
    rd(4'd6, 32'h0, "t5_glitch_status");
    gpio_input[2] = 1'b1;
    repeat (12) @(posedge clk);
    rd(4'd0, 32'h5, "t5_held_input");
    rd(4'd6, 32'h4, "t5_held_status");

    bus(1'b1, 4'd1, 32'hFFFFFFFF, 4'hF, 32'h0, "wr8");
    bus(1'b1, 4'd3, 32'hFFFFFFFF, 4'hF, 32'h0, "wr8");
    bus(1'b1, 4'd1, 32'h0, 4'h0, 32'h000000FF, "t6_rd_out");
    bus(1'b1, 4'd3, 32'h0, 4'h0, 32'h000000FF, "t6_rd_ien");
    check("t6_gpio_out8", {24'b0, gpio_output8}, 32'h000000FF);
    check("t6_irq8", {31'b0, irq8}, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drain", sbq.size(), 32'd0);
    check("sb8_drain", sbq8.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
